// File: rtl/can_tx_scheduler.sv
// CAN transmit scheduler: NUM_SLOTS mailboxes. The lowest pending ID is handed to the
// bit stuffer. The block then waits for done or a timeout and holds an inter-frame gap.
module can_tx_scheduler #(
  parameter int NUM_SLOTS      = 4,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic                         wr_en_i,
  input  logic [$clog2(NUM_SLOTS)-1:0] wr_slot_i,
  input  logic [10:0]                  wr_id_i,
  input  logic [31:0]                  wr_data_i,
  output logic                         wr_reject_o,
  output logic [NUM_SLOTS-1:0]         pending_o,
  output logic                         busy_o,
  output logic                         sent_o,
  output logic                         timeout_o,
  output logic [$clog2(NUM_SLOTS)-1:0] result_slot_o,
  output logic [31:0]                  stf_data_o,
  output logic [10:0]                  stf_msg_id_o,
  output logic                         stf_start_o,
  input  logic                         stf_done_i
);
  localparam int SW = $clog2(NUM_SLOTS);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_GAP} state_t;

  state_t               state_q;
  logic [10:0]          id_q   [NUM_SLOTS];
  logic [31:0]          data_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] pending_q, pending_d;
  logic [SW-1:0]        act_q, res_q;
  logic [TW-1:0]        tcnt_q;
  logic [GW-1:0]        gcnt_q;
  logic [31:0]          stf_data_q;
  logic [10:0]          stf_id_q;
  logic                 start_q, sent_q, to_q, rej_q;

  logic                 in_flight_hit, wr_ok, win_vld;
  logic [SW-1:0]        win_slot;
  logic [10:0]          win_id;

  assign in_flight_hit = (state_q == S_START || state_q == S_WAIT) && (wr_slot_i == act_q);
  assign wr_ok         = wr_en_i && !in_flight_hit && (32'(wr_slot_i) < NUM_SLOTS);

  // Strict less-than keeps the lowest slot index on an ID tie.
  always_comb begin
    win_vld  = 1'b0;
    win_slot = '0;
    win_id   = '1;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (pending_q[i] && (!win_vld || id_q[i] < win_id)) begin
        win_vld  = 1'b1;
        win_slot = SW'(i);
        win_id   = id_q[i];
      end
    end
  end

  always_comb begin
    pending_d = pending_q;
    if (state_q == S_WAIT && stf_done_i) pending_d[act_q] = 1'b0;
    if (wr_ok) pending_d[wr_slot_i] = 1'b1;
  end

  always_ff @(posedge clock_i) begin
    if (wr_ok) begin
      id_q[wr_slot_i]   <= wr_id_i;
      data_q[wr_slot_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      pending_q  <= '0;
      act_q      <= '0;
      res_q      <= '0;
      tcnt_q     <= '0;
      gcnt_q     <= '0;
      stf_data_q <= '0;
      stf_id_q   <= '0;
      start_q    <= 1'b0;
      sent_q     <= 1'b0;
      to_q       <= 1'b0;
      rej_q      <= 1'b0;
    end else begin
      start_q   <= 1'b0;
      sent_q    <= 1'b0;
      to_q      <= 1'b0;
      rej_q     <= wr_en_i && in_flight_hit;
      pending_q <= pending_d;
      case (state_q)
        S_IDLE: if (win_vld) begin
          stf_id_q   <= win_id;
          stf_data_q <= data_q[win_slot];
          act_q      <= win_slot;
          start_q    <= 1'b1;
          state_q    <= S_START;
        end
        S_START: begin
          tcnt_q  <= TW'(TIMEOUT_CYCLES);
          state_q <= S_WAIT;
        end
        // Done has priority over expiry; a timed-out slot stays pending for retry.
        S_WAIT: if (stf_done_i) begin
          sent_q  <= 1'b1;
          res_q   <= act_q;
          gcnt_q  <= GW'(GAP_CYCLES - 1);
          state_q <= S_GAP;
        end else if (tcnt_q == TW'(1)) begin
          to_q    <= 1'b1;
          res_q   <= act_q;
          gcnt_q  <= GW'(GAP_CYCLES - 1);
          state_q <= S_GAP;
        end else begin
          tcnt_q <= tcnt_q - TW'(1);
        end
        S_GAP: if (gcnt_q == '0) state_q <= S_IDLE;
               else gcnt_q <= gcnt_q - GW'(1);
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wr_reject_o   = rej_q;
  assign pending_o     = pending_q;
  assign busy_o        = (state_q != S_IDLE);
  assign sent_o        = sent_q;
  assign timeout_o     = to_q;
  assign result_slot_o = res_q;
  assign stf_data_o    = stf_data_q;
  assign stf_msg_id_o  = stf_id_q;
  assign stf_start_o   = start_q;
endmodule

// File: tb/tb_can_tx_scheduler.sv
// Scenario bench for can_tx_scheduler. Expected frames and results are queued as stimulus
// is driven, and a negedge monitor pops and compares them on start/sent/timeout.
module tb_can_tx_scheduler;
  localparam int NS = 4;
  localparam int G  = 4;
  localparam int T  = 50;

  logic        clock_i = 1'b0, reset_i = 1'b1;
  logic        wr_en_i = 1'b0;
  logic [1:0]  wr_slot_i = '0;
  logic [10:0] wr_id_i = '0;
  logic [31:0] wr_data_i = '0;
  logic        stf_done_i = 1'b0;
  logic        wr_reject_o, busy_o, sent_o, timeout_o, stf_start_o;
  logic [NS-1:0] pending_o;
  logic [1:0]  result_slot_o;
  logic [31:0] stf_data_o;
  logic [10:0] stf_msg_id_o;

  can_tx_scheduler #(.NUM_SLOTS(NS), .GAP_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .wr_en_i(wr_en_i), .wr_slot_i(wr_slot_i),
    .wr_id_i(wr_id_i), .wr_data_i(wr_data_i), .wr_reject_o(wr_reject_o),
    .pending_o(pending_o), .busy_o(busy_o), .sent_o(sent_o), .timeout_o(timeout_o),
    .result_slot_o(result_slot_o), .stf_data_o(stf_data_o), .stf_msg_id_o(stf_msg_id_o),
    .stf_start_o(stf_start_o), .stf_done_i(stf_done_i));

  always #5 clock_i = ~clock_i;

  typedef struct { logic [10:0] id; logic [31:0] data; } exp_t;
  typedef struct { logic [1:0] slot; logic to; } res_t;

  exp_t exp_q[$];
  res_t res_q[$];
  exp_t ef;
  res_t rf;
  int   cyc = 0;
  int   checks = 0, errors = 0;

  always @(posedge clock_i) cyc <= cyc + 1;

  // Scoreboard monitor
  always @(negedge clock_i) begin
    if (stf_start_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL start_unexpected cyc=%0d id=%h", cyc, stf_msg_id_o);
      end else begin
        ef = exp_q.pop_front();
        if (stf_msg_id_o !== ef.id || stf_data_o !== ef.data) begin
          errors++;
          $display("FAIL start_frame cyc=%0d got id=%h data=%h exp id=%h data=%h",
                   cyc, stf_msg_id_o, stf_data_o, ef.id, ef.data);
        end
      end
    end
    if (sent_o === 1'b1 || timeout_o === 1'b1) begin
      checks++;
      if (res_q.size() == 0) begin
        errors++; $display("FAIL result_unexpected cyc=%0d sent=%b to=%b", cyc, sent_o, timeout_o);
      end else begin
        rf = res_q.pop_front();
        if (result_slot_o !== rf.slot || timeout_o !== rf.to || sent_o !== !rf.to) begin
          errors++;
          $display("FAIL result cyc=%0d got slot=%0d sent=%b to=%b exp slot=%0d to=%b",
                   cyc, result_slot_o, sent_o, timeout_o, rf.slot, rf.to);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock_i);
    #1;
  endtask

  task automatic wr(input int slot, input logic [10:0] id, input logic [31:0] d, output int n);
    wr_en_i = 1'b1; wr_slot_i = 2'(slot); wr_id_i = id; wr_data_i = d;
    n = cyc;
    tick(1);
    wr_en_i = 1'b0;
  endtask

  task automatic pulse_done(output int d);
    stf_done_i = 1'b1;
    d = cyc;
    tick(1);
    stf_done_i = 1'b0;
  endtask

  // which: 0 = stf_start_o, 1 = sent_o, 2 = timeout_o
  task automatic wait_evt(input int which, input int budget, input string nm, output int at);
    at = -1;
    for (int i = 0; i < budget && at < 0; i++) begin
      @(negedge clock_i);
      if ((which == 0 && stf_start_o === 1'b1) || (which == 1 && sent_o === 1'b1) ||
          (which == 2 && timeout_o === 1'b1)) at = cyc;
    end
    checks++;
    if (at < 0) begin errors++; $display("FAIL %s no event within %0d cycles", nm, budget); end
  endtask

  task automatic test_reset;
    reset_i = 1'b1;
    tick(3);
    reset_i = 1'b0;
    checks++;
    if ({busy_o, sent_o, timeout_o, stf_start_o, wr_reject_o} !== 5'b0 || pending_o !== '0) begin
      errors++; $display("FAIL reset_flags busy=%b pend=%b exp all 0", busy_o, pending_o);
    end
    checks++;
    if (stf_data_o !== '0 || stf_msg_id_o !== '0 || result_slot_o !== '0) begin
      errors++;
      $display("FAIL reset_regs data=%h id=%h slot=%0d exp 0", stf_data_o, stf_msg_id_o, result_slot_o);
    end
  endtask

  task automatic test_basic;
    int n, s, d, a;
    exp_q.push_back('{11'h123, 32'hDEADBEEF});
    wr(0, 11'h123, 32'hDEADBEEF, n);
    wait_evt(0, 10, "basic_start", s);
    checks++;
    if (s != n + 2) begin errors++; $display("FAIL basic_latency got %0d exp %0d", s - n, 2); end
    tick(1);
    checks++;
    if (pending_o !== 4'b0001) begin errors++; $display("FAIL basic_pend_wait got %b exp 0001", pending_o); end
    res_q.push_back('{2'd0, 1'b0});
    pulse_done(d);
    wait_evt(1, 10, "basic_sent", a);
    checks++;
    if (a != d + 1 || pending_o !== '0 || result_slot_o !== 2'd0) begin
      errors++; $display("FAIL basic_sent at=%0d exp %0d pend=%b slot=%0d", a, d + 1, pending_o, result_slot_o);
    end
    tick(G + 1);
  endtask

  task automatic test_priority;
    int n, s, d, a;
    int ord[3] = '{2, 3, 1};
    exp_q.push_back('{11'h100, 32'h0A0A0A0A});
    wr(0, 11'h100, 32'h0A0A0A0A, n);
    wait_evt(0, 10, "prio_start0", s);
    tick(1);
    wr(1, 11'h200, 32'h11111111, n);
    wr(2, 11'h050, 32'h22222222, n);
    wr(3, 11'h050, 32'h33333333, n);
    checks++;
    if (pending_o !== 4'b1111) begin errors++; $display("FAIL prio_pend got %b exp 1111", pending_o); end
    exp_q.push_back('{11'h050, 32'h22222222});
    exp_q.push_back('{11'h050, 32'h33333333});
    exp_q.push_back('{11'h200, 32'h11111111});
    res_q.push_back('{2'd0, 1'b0});
    pulse_done(d);
    for (int k = 0; k < 3; k++) begin
      wait_evt(1, 10, "prio_sent", a);
      wait_evt(0, G + 10, "prio_start", s);
      checks++;
      if (s != d + G + 2) begin errors++; $display("FAIL prio_b2b slot=%0d got %0d exp %0d", ord[k], s - d, G + 2); end
      tick(1);
      res_q.push_back('{2'(ord[k]), 1'b0});
      pulse_done(d);
    end
    wait_evt(1, 10, "prio_sent_last", a);
    tick(G + 1);
  endtask

  task automatic test_reject;
    int n, s, d, a;
    exp_q.push_back('{11'h010, 32'hAAAA0000});
    wr(0, 11'h010, 32'hAAAA0000, n);
    wait_evt(0, 10, "rej_start", s);
    tick(1);
    wr(0, 11'h010, 32'hBBBB1111, n);
    checks++;
    if (wr_reject_o !== 1'b1 || stf_data_o !== 32'hAAAA0000) begin
      errors++; $display("FAIL rej_inflight rej=%b data=%h exp 1 AAAA0000", wr_reject_o, stf_data_o);
    end
    wr(1, 11'h020, 32'hBBBB1111, n);
    checks++;
    if (wr_reject_o !== 1'b0 || pending_o !== 4'b0011) begin
      errors++; $display("FAIL rej_other rej=%b pend=%b exp 0 0011", wr_reject_o, pending_o);
    end
    exp_q.push_back('{11'h020, 32'hBBBB1111});
    res_q.push_back('{2'd0, 1'b0});
    pulse_done(d);
    wait_evt(1, 10, "rej_sent0", a);
    checks++;
    if (pending_o !== 4'b0010) begin errors++; $display("FAIL rej_pend got %b exp 0010", pending_o); end
    wait_evt(0, G + 10, "rej_start1", s);
    tick(1);
    res_q.push_back('{2'd1, 1'b0});
    pulse_done(d);
    wait_evt(1, 10, "rej_sent1", a);
    tick(G + 1);
  endtask

  task automatic test_timeout;
    int n, s, t, s2, d, a;
    exp_q.push_back('{11'h300, 32'hC0C0C0C0});
    wr(2, 11'h300, 32'hC0C0C0C0, n);
    wait_evt(0, 10, "to_start", s);
    res_q.push_back('{2'd2, 1'b1});
    exp_q.push_back('{11'h300, 32'hC0C0C0C0});
    wait_evt(2, T + 10, "to_pulse", t);
    checks++;
    if (t != s + 1 + T || pending_o !== 4'b0100 || result_slot_o !== 2'd2) begin
      errors++;
      $display("FAIL to_pulse at=%0d exp %0d pend=%b slot=%0d", t - s, T + 1, pending_o, result_slot_o);
    end
    wait_evt(0, G + 10, "to_restart", s2);
    checks++;
    if (s2 != t + G + 1) begin errors++; $display("FAIL to_restart got %0d exp %0d", s2 - t, G + 1); end
    tick(1);
    res_q.push_back('{2'd2, 1'b0});
    pulse_done(d);
    wait_evt(1, 10, "to_sent", a);
    tick(G + 1);
  endtask

  task automatic test_boundary;
    int n, s, d, a;
    exp_q.push_back('{11'h055, 32'hD00DD00D});
    wr(3, 11'h055, 32'hD00DD00D, n);
    wait_evt(0, 10, "bnd_start", s);
    tick(T);
    res_q.push_back('{2'd3, 1'b0});
    pulse_done(d);
    wait_evt(1, 10, "bnd_sent", a);
    checks++;
    if (a != s + T + 1 || timeout_o !== 1'b0) begin
      errors++; $display("FAIL bnd_done_wins at=%0d exp %0d to=%b", a - s, T + 1, timeout_o);
    end
    tick(1);
    pulse_done(d);
    tick(G + 2);
    pulse_done(d);
    tick(2);
    checks++;
    if (busy_o !== 1'b0 || pending_o !== '0 || sent_o !== 1'b0) begin
      errors++; $display("FAIL bnd_spurious busy=%b pend=%b sent=%b exp 0", busy_o, pending_o, sent_o);
    end
  endtask

  task automatic test_reset_mid;
    int n, s;
    exp_q.push_back('{11'h0AA, 32'h12345678});
    wr(1, 11'h0AA, 32'h12345678, n);
    wait_evt(0, 10, "rst_start", s);
    tick(2);
    reset_i = 1'b1;
    tick(1);
    reset_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || pending_o !== '0 || sent_o !== 1'b0 || timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid busy=%b pend=%b sent=%b to=%b exp 0", busy_o, pending_o, sent_o, timeout_o);
    end
    checks++;
    if (stf_data_o !== '0 || result_slot_o !== '0) begin
      errors++; $display("FAIL rst_mid_regs data=%h slot=%0d exp 0", stf_data_o, result_slot_o);
    end
    tick(T + G + 10);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "global timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_reject();
    test_timeout();
    test_boundary();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0 || res_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain frames=%0d results=%0d exp 0", exp_q.size(), res_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
